// File: rtl/if_fetch_pkg.sv
// Shared widths and FSM encodings for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int unsigned PC_mem_AddrBus = 8;
    localparam int unsigned INST_W         = 32;
    localparam int unsigned CNT_W          = 16;

    typedef enum logic [1:0] {
        StFetch   = 2'd0,
        StHold    = 2'd1,
        StDiscard = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction that arrived while decode was stalled.
module fetch_skid
    import if_fetch_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      pop,
    input  logic                      clear,
    input  logic [INST_W-1:0]         wr_data,
    input  logic [PC_mem_AddrBus-1:0] wr_pc,
    output logic [INST_W-1:0]         data,
    output logic [PC_mem_AddrBus-1:0] pc,
    output logic                      full
);

    logic [INST_W-1:0]         data_q;
    logic [PC_mem_AddrBus-1:0] pc_q;
    logic                      full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            pc_q   <= '0;
            full_q <= 1'b0;
        end else if (clear) begin
            full_q <= 1'b0;
        end else if (load) begin
            data_q <= wr_data;
            pc_q   <= wr_pc;
            full_q <= 1'b1;
        end else if (pop) begin
            full_q <= 1'b0;
        end
    end

    assign data = data_q;
    assign pc   = pc_q;
    assign full = full_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: request/ack memory port, IF/ID register and skid buffer.
// Define FETCH_CNT_EN to build the delivered-instruction counter on fetch_cnt.
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PC_mem_AddrBus-1:0] NPC,
    input  logic                      flush,
    input  logic                      wait_ID,
    output logic                      imem_req,
    output logic [PC_mem_AddrBus-1:0] imem_addr,
    input  logic                      imem_ack,
    input  logic [INST_W-1:0]         imem_data,
    output logic [PC_mem_AddrBus-1:0] PC,
    output logic [INST_W-1:0]         IR,
    output logic [PC_mem_AddrBus-1:0] IR_PC,
    output logic                      IR_valid,
    output logic [CNT_W-1:0]          fetch_cnt
);

    fetch_state_e              state_q, state_d;
    logic [PC_mem_AddrBus-1:0] pc_q, pc_d;
    logic [PC_mem_AddrBus-1:0] req_addr_q, req_addr_d;
    logic [INST_W-1:0]         ir_q, ir_d;
    logic [PC_mem_AddrBus-1:0] ir_pc_q, ir_pc_d;
    logic                      ir_valid_q, ir_valid_d;
    logic                      ir_free, ir_load;
    logic                      skid_load, skid_pop, skid_clear, skid_full;
    logic [INST_W-1:0]         skid_data;
    logic [PC_mem_AddrBus-1:0] skid_pc;

    fetch_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .pop     (skid_pop),
        .clear   (skid_clear),
        .wr_data (imem_data),
        .wr_pc   (req_addr_q),
        .data    (skid_data),
        .pc      (skid_pc),
        .full    (skid_full)
    );

    assign ir_free = !ir_valid_q || !wait_ID;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        ir_load    = 1'b0;
        skid_load  = 1'b0;
        skid_pop   = 1'b0;
        skid_clear = 1'b0;

        // A free IR has been consumed by decode; it stays live only if reloaded below.
        if (ir_free) ir_valid_d = 1'b0;

        if (flush) begin
            ir_valid_d = 1'b0;
            skid_clear = 1'b1;
            pc_d       = NPC;
        end

        unique case (state_q)
            StFetch: begin
                if (flush) begin
                    if (imem_ack) req_addr_d = NPC;
                    else          state_d    = StDiscard;
                end else if (imem_ack) begin
                    pc_d       = NPC;
                    req_addr_d = NPC;
                    if (ir_free) begin
                        ir_d       = imem_data;
                        ir_pc_d    = req_addr_q;
                        ir_valid_d = 1'b1;
                        ir_load    = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = StHold;
                    end
                end
            end
            StHold: begin
                if (flush) begin
                    req_addr_d = NPC;
                    state_d    = StFetch;
                end else if (!wait_ID) begin
                    ir_d       = skid_data;
                    ir_pc_d    = skid_pc;
                    ir_valid_d = skid_full;
                    ir_load    = skid_full;
                    skid_pop   = 1'b1;
                    state_d    = StFetch;
                end
            end
            StDiscard: begin
                // The stale response is dropped; refetch from the redirected PC.
                if (imem_ack) begin
                    req_addr_d = flush ? NPC : pc_q;
                    state_d    = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            pc_q       <= '0;
            req_addr_q <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign imem_req  = !rst && (state_q != StHold);
    assign imem_addr = req_addr_q;
    assign PC        = pc_q;
    assign IR        = ir_q;
    assign IR_PC     = ir_pc_q;
    assign IR_valid  = ir_valid_q;

`ifdef FETCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)          cnt_q <= '0;
        else if (ir_load) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign fetch_cnt = cnt_q;
`else
    logic unused_ir_load;
    assign unused_ir_load = ir_load;
    assign fetch_cnt      = '0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch.
module tb_if_fetch;

`ifdef FETCH_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic        clk, rst, flush, wait_ID, imem_req, imem_ack, IR_valid;
    logic [7:0]  NPC, imem_addr, PC, IR_PC;
    logic [31:0] imem_data, IR;
    logic [15:0] fetch_cnt;
    int          tests_run, tests_failed;

    if_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .NPC       (NPC),
        .flush     (flush),
        .wait_ID   (wait_ID),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .PC        (PC),
        .IR        (IR),
        .IR_PC     (IR_PC),
        .IR_valid  (IR_valid),
        .fetch_cnt (fetch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic [31:0] data, input logic [7:0] npc,
                         input logic wt, input logic fl);
        imem_ack  = ack;
        imem_data = data;
        NPC       = npc;
        wait_ID   = wt;
        flush     = fl;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        step();
        step();
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++; $display("FAIL reset_req: got %b want 0", imem_req);
        end
        tests_run++;
        if ({PC, IR_PC, IR, IR_valid, fetch_cnt} !== 65'h0) begin
            tests_failed++;
            $display("FAIL reset_vals: PC=%h IR_PC=%h IR=%h vld=%b cnt=%h want all 0",
                     PC, IR_PC, IR, IR_valid, fetch_cnt);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_first_req: req=%b addr=%h want 1/00", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA000_0000 + i, 8'(i + 1), 1'b0, 1'b0);
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== 8'(i)) begin
                tests_failed++;
                $display("FAIL stream_req%0d: req=%b addr=%h want 1/%h", i, imem_req, imem_addr,
                         8'(i));
            end
            step();
            tests_run++;
            if (IR_PC !== 8'(i) || IR !== 32'hA000_0000 + i || IR_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream_ir%0d: IR_PC=%h IR=%h vld=%b want %h/%h/1", i, IR_PC, IR,
                         IR_valid, 8'(i), 32'hA000_0000 + i);
            end
        end
        tests_run++;
        if (fetch_cnt !== (CntEn ? 16'd3 : 16'd0)) begin
            tests_failed++;
            $display("FAIL stream_cnt: got %0d want %0d", fetch_cnt, CntEn ? 3 : 0);
        end
        drive(1'b0, 32'h0, 8'h04, 1'b0, 1'b0);
        step();
        tests_run++;
        if (IR_valid !== 1'b0 || imem_addr !== 8'h03) begin
            tests_failed++;
            $display("FAIL stream_drain: vld=%b addr=%h want 0/03", IR_valid, imem_addr);
        end
    endtask

    task automatic test_delayed_ack();
        apply_reset();
        drive(1'b1, 32'h1111_0000, 8'h05, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(k == 3, 32'hDEAD_0005, 8'h06, 1'b0, 1'b0);
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== 8'h05) begin
                tests_failed++;
                $display("FAIL delay_req%0d: req=%b addr=%h want 1/05", k, imem_req, imem_addr);
            end
            step();
            if (k == 0) begin
                tests_run++;
                if (IR_valid !== 1'b0) begin
                    tests_failed++; $display("FAIL delay_novld: got %b want 0", IR_valid);
                end
            end
        end
        tests_run++;
        if (IR !== 32'hDEAD_0005 || IR_PC !== 8'h05 || IR_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL delay_ir: IR=%h IR_PC=%h vld=%b want dead0005/05/1", IR, IR_PC,
                     IR_valid);
        end
    endtask

    task automatic test_stall_hold();
        apply_reset();
        drive(1'b1, 32'hC0DE_0000, 8'h01, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(k == 0, 32'hC0DE_0001, 8'h02, 1'b1, 1'b0);
            step();
            tests_run++;
            if (IR !== 32'hC0DE_0000 || IR_PC !== 8'h00 || IR_valid !== 1'b1 ||
                imem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold%0d: IR=%h IR_PC=%h vld=%b req=%b want c0de0000/00/1/0", k,
                         IR, IR_PC, IR_valid, imem_req);
            end
        end
        drive(1'b0, 32'h0, 8'h02, 1'b0, 1'b0);
        step();
        tests_run++;
        if (IR !== 32'hC0DE_0001 || IR_PC !== 8'h01 || IR_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_release: IR=%h IR_PC=%h vld=%b want c0de0001/01/1", IR, IR_PC,
                     IR_valid);
        end
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h02 || fetch_cnt !== (CntEn ? 16'd2 : 16'd0))
        begin
            tests_failed++;
            $display("FAIL hold_resume: req=%b addr=%h cnt=%0d want 1/02/%0d", imem_req,
                     imem_addr, fetch_cnt, CntEn ? 2 : 0);
        end
    endtask

    task automatic test_flush_discard();
        apply_reset();
        drive(1'b1, 32'h5555_0000, 8'h10, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 8'h40, 1'b0, 1'b1);
        step();
        tests_run++;
        if (IR_valid !== 1'b0 || PC !== 8'h40 || imem_req !== 1'b1 || imem_addr !== 8'h10) begin
            tests_failed++;
            $display("FAIL discard_enter: vld=%b PC=%h req=%b addr=%h want 0/40/1/10", IR_valid,
                     PC, imem_req, imem_addr);
        end
        drive(1'b0, 32'h0, 8'h41, 1'b0, 1'b0);
        step();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin
            tests_failed++;
            $display("FAIL discard_hold: req=%b addr=%h want 1/10", imem_req, imem_addr);
        end
        drive(1'b1, 32'hBAD0_0010, 8'h41, 1'b0, 1'b0);
        step();
        tests_run++;
        if (IR_valid !== 1'b0 || IR === 32'hBAD0_0010 || imem_addr !== 8'h40 ||
            imem_req !== 1'b1 || PC !== 8'h40) begin
            tests_failed++;
            $display("FAIL discard_drop: vld=%b IR=%h addr=%h req=%b PC=%h want 0/!bad/40/1/40",
                     IR_valid, IR, imem_addr, imem_req, PC);
        end
        drive(1'b1, 32'h0000_0040, 8'h41, 1'b0, 1'b0);
        step();
        tests_run++;
        if (IR !== 32'h0000_0040 || IR_PC !== 8'h40 || IR_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL discard_refetch: IR=%h IR_PC=%h vld=%b want 00000040/40/1", IR,
                     IR_PC, IR_valid);
        end
    endtask

    task automatic test_flush_ack();
        apply_reset();
        drive(1'b1, 32'h7777_0000, 8'h01, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hBAD0_0001, 8'h20, 1'b1, 1'b1);
        step();
        tests_run++;
        if (IR_valid !== 1'b0 || IR !== 32'h7777_0000 || imem_addr !== 8'h20 ||
            imem_req !== 1'b1 || PC !== 8'h20) begin
            tests_failed++;
            $display("FAIL flush_ack: vld=%b IR=%h addr=%h req=%b PC=%h want 0/77770000/20/1/20",
                     IR_valid, IR, imem_addr, imem_req, PC);
        end
        tests_run++;
        if (fetch_cnt !== (CntEn ? 16'd1 : 16'd0)) begin
            tests_failed++;
            $display("FAIL flush_ack_cnt: got %0d want %0d", fetch_cnt, CntEn ? 1 : 0);
        end
        drive(1'b1, 32'h7777_0020, 8'h21, 1'b0, 1'b0);
        step();
        tests_run++;
        if (IR !== 32'h7777_0020 || IR_PC !== 8'h20 || IR_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_ack_next: IR=%h IR_PC=%h vld=%b want 77770020/20/1", IR, IR_PC,
                     IR_valid);
        end
    endtask

    task automatic test_wrap_and_rst();
        apply_reset();
        drive(1'b1, 32'h0, 8'hFF, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hFFFF_00FF, 8'h00, 1'b0, 1'b0);
        step();
        tests_run++;
        if (IR_PC !== 8'hFF || IR !== 32'hFFFF_00FF || PC !== 8'h00 || imem_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL wrap: IR_PC=%h IR=%h PC=%h addr=%h want ff/ffff00ff/00/00", IR_PC, IR,
                     PC, imem_addr);
        end
        drive(1'b1, 32'h1234_0000, 8'h01, 1'b1, 1'b0);
        step();
        tests_run++;
        if (imem_req !== 1'b0 || PC !== 8'h01) begin
            tests_failed++;
            $display("FAIL wrap_hold: req=%b PC=%h want 0/01", imem_req, PC);
        end
        rst = 1'b1;
        drive(1'b0, 32'h0, 8'h01, 1'b1, 1'b0);
        step();
        tests_run++;
        if ({PC, IR_PC, IR, IR_valid, fetch_cnt, imem_addr} !== 73'h0 || imem_req !== 1'b0)
        begin
            tests_failed++;
            $display("FAIL hold_rst: PC=%h IR_PC=%h IR=%h vld=%b cnt=%h addr=%h req=%b want 0",
                     PC, IR_PC, IR, IR_valid, fetch_cnt, imem_addr, imem_req);
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 8'h01, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL hold_rst_req: req=%b addr=%h want 1/00", imem_req, imem_addr);
        end
        step();
        tests_run++;
        if (IR_valid !== 1'b0 || imem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_rst_skid: vld=%b req=%b want 0/1", IR_valid, imem_req);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        test_reset();
        test_stream();
        test_delayed_ack();
        test_stall_hold();
        test_flush_discard();
        test_flush_ack();
        test_wrap_and_rst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
